// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI slave that streams one zero-padded ADC sample (external or ramp) per CS frame.
// CS and SCLK are oversampled on CLK50; data shifts out MSB first on SCLK falling edges.
module adc_spi_responder #(
    parameter int DATA_BITS  = 12,
    parameter int FRAME_BITS = 16
) (
    input  logic                 CLK50,
    input  logic                 MSS_RESET_N,
    input  logic                 CS,
    input  logic                 SCLK,
    output logic                 MISO,
    input  logic [DATA_BITS-1:0] sample_in,
    input  logic                 pattern_en,
    output logic                 frame_done,
    output logic                 frame_abort,
    output logic [15:0]          frame_count
);
    localparam int CW = $clog2(FRAME_BITS + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    state_t                state_q, state_d;
    logic [1:0]            cs_sync_q, sclk_sync_q, flush_q;
    logic                  cs_prev_q, sclk_prev_q, armed_q;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  ramp_q, ramp_d;
    logic [15:0]           frame_count_q, frame_count_d;
    logic                  done_q, done_d, abort_q, abort_d;
    logic                  cs_fall, cs_rise, sclk_fall;
    // A frame may only start after a genuine CS high has crossed the synchronizer since reset,
    // so a CS held low through reset release is not mistaken for a falling edge.
    assign cs_fall   = armed_q & cs_prev_q & ~cs_sync_q[1];
    assign cs_rise   = ~cs_prev_q & cs_sync_q[1];
    assign sclk_fall = sclk_prev_q & ~sclk_sync_q[1];
    assign MISO        = shift_q[FRAME_BITS-1];
    assign frame_done  = done_q;
    assign frame_abort = abort_q;
    assign frame_count = frame_count_q;
    always_ff @(posedge CLK50) begin
        if (!MSS_RESET_N) begin
            state_q       <= IDLE;
            cs_sync_q     <= 2'b11;
            sclk_sync_q   <= 2'b11;
            cs_prev_q     <= 1'b1;
            sclk_prev_q   <= 1'b1;
            flush_q       <= 2'b00;
            armed_q       <= 1'b0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            ramp_q        <= '0;
            frame_count_q <= '0;
            done_q        <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cs_sync_q     <= {cs_sync_q[0], CS};
            sclk_sync_q   <= {sclk_sync_q[0], SCLK};
            cs_prev_q     <= cs_sync_q[1];
            sclk_prev_q   <= sclk_sync_q[1];
            flush_q       <= {flush_q[0], 1'b1};
            armed_q       <= armed_q | (flush_q[1] & cs_sync_q[1]);
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            ramp_q        <= ramp_d;
            frame_count_q <= frame_count_d;
            done_q        <= done_d;
            abort_q       <= abort_d;
        end
    end
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        ramp_d        = ramp_q;
        frame_count_d = frame_count_q;
        done_d        = 1'b0;
        abort_d       = 1'b0;
        case (state_q)
            IDLE: if (cs_fall) begin
                shift_d   = FRAME_BITS'(pattern_en ? ramp_q : sample_in);
                bit_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: if (cs_rise) begin
                abort_d = 1'b1;
                shift_d = '0;
                state_d = IDLE;
            end else if (sclk_fall) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                shift_d   = shift_q << 1;
                if (bit_cnt_q == CW'(FRAME_BITS - 1)) begin
                    shift_d       = '0;
                    done_d        = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    ramp_d        = ramp_q + 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule
